// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV64 core: fetch, decode, execute, memory
// and writeback sequencing for a subset of RV64I, with handshake timeout.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_sel,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        halt,
  output logic        err
);

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q;
  logic [CW-1:0]   wait_cnt;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            branch_taken;

  // Only opcode, funct3 and the branch funct3 bits steer control.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: return 3'd0;
      OP_STORE:                 return 3'd1;
      OP_BRANCH:                return 3'd2;
      OP_LUI:                   return 3'd3;
      OP_JAL:                   return 3'd4;
      default:                  return 3'd7;
    endcase
  endfunction

  // NOTE: all state is updated with non-blocking assignments so every branch
  // of the case sees the pre-edge values of state_q and wait_cnt.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_START;
      wait_cnt <= '0;
      opcode   <= '0;
      funct3   <= '0;
      imm_sel  <= 3'd7;
    end else begin
      case (state_q)
        S_START: begin
          wait_cnt <= '0;
          state_q  <= S_FETCH;
        end
        S_FETCH, S_MEM: begin
          // A handshake in the final allowed cycle still completes.
          if (mem_ready) begin
            wait_cnt <= '0;
            if (state_q == S_FETCH)      state_q <= S_DECODE;
            else if (opcode == OP_STORE) state_q <= S_FETCH;
            else                         state_q <= S_WB;
          end else if (wait_cnt == CNT_LAST) begin
            state_q <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          opcode   <= instr[6:0];
          funct3   <= instr[14:12];
          imm_sel  <= imm_of(instr[6:0]);
          case (instr[6:0])
            OP_SYSTEM: state_q <= S_HALT;
            OP_BRANCH: state_q <= (instr[14:13] == 2'b00) ? S_EXEC : S_TRAP;
            OP_REG, OP_IMM, OP_LOAD, OP_STORE,
            OP_LUI, OP_JAL, OP_JALR: state_q <= S_EXEC;
            default:   state_q <= S_TRAP;
          endcase
        end
        S_EXEC: begin
          wait_cnt <= '0;
          case (opcode)
            OP_REG, OP_IMM, OP_LUI:   state_q <= S_WB;
            OP_LOAD, OP_STORE:        state_q <= S_MEM;
            OP_BRANCH, OP_JAL, OP_JALR: state_q <= S_FETCH;
            default:                  state_q <= S_TRAP;
          endcase
        end
        S_WB: begin
          wait_cnt <= '0;
          state_q  <= S_FETCH;
        end
        default: begin
          wait_cnt <= '0;
          state_q  <= state_q;
        end
      endcase
    end
  end

  assign branch_taken = ((funct3 == 3'b000) &&  zero) ||
                        ((funct3 == 3'b001) && !zero);

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    alu_src_b = 1'b0;
    alu_op    = 2'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    halt      = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        case (opcode)
          OP_REG: alu_op = 2'd2;
          OP_IMM: begin
            alu_op    = 2'd2;
            alu_src_b = 1'b1;
          end
          OP_LUI: begin
            alu_op    = 2'd3;
            alu_src_b = 1'b1;
          end
          OP_LOAD, OP_STORE: alu_src_b = 1'b1;
          OP_BRANCH: begin
            alu_op = 2'd1;
            if (branch_taken) begin
              pc_write = 1'b1;
              pc_src   = 2'd1;
            end
          end
          OP_JAL: begin
            pc_write  = 1'b1;
            pc_src    = 2'd1;
            reg_write = 1'b1;
            wb_sel    = 2'd2;
          end
          OP_JALR: begin
            alu_src_b = 1'b1;
            pc_write  = 1'b1;
            pc_src    = 2'd2;
            reg_write = 1'b1;
            wb_sel    = 2'd2;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
      end
      S_HALT: halt = 1'b1;
      S_TRAP: err  = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues the expected output
// snapshot of each cycle, a monitor compares it against the DUT mid-cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic        ir_write, pc_write, alu_src_b, mem_req, mem_we, reg_write, halt, err;
  logic [1:0]  pc_src, alu_op, wb_sel;
  logic [2:0]  imm_sel, state;

  typedef struct packed {
    logic [2:0] st;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic [2:0] imm;
    logic       srcb;
    logic [1:0] aop;
    logic       mreq;
    logic       mwe;
    logic       rw;
    logic [1:0] wbs;
    logic       hlt;
    logic       er;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad = 0;
  logic [2:0] cur_imm = 3'd7;

  multicycle_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .mem_ready(mem_ready),
    .zero(zero), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .imm_sel(imm_sel), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write),
    .wb_sel(wb_sel), .state(state), .halt(halt), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor: one snapshot comparison per queued cycle, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t  e;
        exp_t  got;
        string t;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = {state, ir_write, pc_write, pc_src, imm_sel, alu_src_b, alu_op,
               mem_req, mem_we, reg_write, wb_sel, halt, err};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL %s: got state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                   t, got.st, got, e.st, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t base(input logic [2:0] st);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.imm = cur_imm;
    return e;
  endfunction

  task automatic tick(input logic rst, input logic rdy, input logic z,
                      input exp_t e, input string tag);
    reset_n   = rst;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int nwait);
    exp_t e;
    for (int i = 0; i < nwait; i++) begin
      e = base(3'd1); e.mreq = 1'b1;
      tick(1'b1, 1'b0, 1'b0, e, "fetch_wait");
    end
    e = base(3'd1); e.mreq = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    tick(1'b1, 1'b1, 1'b0, e, "fetch_done");
  endtask

  task automatic do_decode(input logic [2:0] new_imm, input string tag);
    tick(1'b1, 1'b0, 1'b0, base(3'd2), tag);
    cur_imm = new_imm;
  endtask

  task automatic do_mem(input int nwait, input logic we, input string tag);
    exp_t e;
    for (int i = 0; i < nwait; i++) begin
      e = base(3'd4); e.mreq = 1'b1; e.mwe = we;
      tick(1'b1, 1'b0, 1'b0, e, tag);
    end
    e = base(3'd4); e.mreq = 1'b1; e.mwe = we;
    tick(1'b1, 1'b1, 1'b0, e, tag);
  endtask

  // Reset from a known state: that cycle still shows e, then START follows.
  task automatic do_reset(input exp_t e, input string tag);
    tick(1'b0, 1'b0, 1'b0, e, tag);
    cur_imm = 3'd7;
    tick(1'b1, 1'b0, 1'b0, base(3'd0), "start_after_reset");
  endtask

  initial begin
    exp_t e;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cur_imm = 3'd7;

    // addi x1,x0,5 with ready on the second fetch cycle
    instr = 32'h00500093;
    tick(1'b1, 1'b0, 1'b0, base(3'd0), "reset_start");
    do_fetch(1);
    do_decode(3'd0, "addi_decode");
    e = base(3'd3); e.aop = 2'd2; e.srcb = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "addi_exec");
    e = base(3'd5); e.rw = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "addi_wb");

    // sw with memory ready after three wait cycles
    instr = 32'h00112023;
    do_fetch(0);
    do_decode(3'd1, "sw_decode");
    e = base(3'd3); e.srcb = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "sw_exec");
    do_mem(3, 1'b1, "sw_mem");

    // add x3,x1,x2
    instr = 32'h002081B3;
    do_fetch(0);
    do_decode(3'd7, "add_decode");
    e = base(3'd3); e.aop = 2'd2;
    tick(1'b1, 1'b0, 1'b0, e, "add_exec");
    e = base(3'd5); e.rw = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "add_wb");

    // lui x1,1
    instr = 32'h000010B7;
    do_fetch(0);
    do_decode(3'd3, "lui_decode");
    e = base(3'd3); e.aop = 2'd3; e.srcb = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "lui_exec");
    e = base(3'd5); e.rw = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "lui_wb");

    // lw x1,0(x2), full path through WB
    instr = 32'h00012083;
    do_fetch(0);
    do_decode(3'd0, "lw_decode");
    e = base(3'd3); e.srcb = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "lw_exec");
    do_mem(1, 1'b0, "lw_mem");
    e = base(3'd5); e.rw = 1'b1; e.wbs = 2'd1;
    tick(1'b1, 1'b0, 1'b0, e, "lw_wb");

    // beq taken (zero=1)
    instr = 32'h00000463;
    do_fetch(0);
    do_decode(3'd2, "beq_decode");
    e = base(3'd3); e.aop = 2'd1; e.pcw = 1'b1; e.pcs = 2'd1;
    tick(1'b1, 1'b0, 1'b1, e, "beq_taken_exec");

    // beq not taken (zero=0)
    do_fetch(0);
    do_decode(3'd2, "beq_decode2");
    e = base(3'd3); e.aop = 2'd1;
    tick(1'b1, 1'b0, 1'b0, e, "beq_not_taken_exec");

    // bne taken (zero=0)
    instr = 32'h00001463;
    do_fetch(0);
    do_decode(3'd2, "bne_decode");
    e = base(3'd3); e.aop = 2'd1; e.pcw = 1'b1; e.pcs = 2'd1;
    tick(1'b1, 1'b0, 1'b0, e, "bne_taken_exec");

    // jal x1,8
    instr = 32'h008000EF;
    do_fetch(0);
    do_decode(3'd4, "jal_decode");
    e = base(3'd3); e.pcw = 1'b1; e.pcs = 2'd1; e.rw = 1'b1; e.wbs = 2'd2;
    tick(1'b1, 1'b0, 1'b0, e, "jal_exec");

    // jalr x1,0(x1)
    instr = 32'h000080E7;
    do_fetch(0);
    do_decode(3'd0, "jalr_decode");
    e = base(3'd3); e.srcb = 1'b1; e.pcw = 1'b1; e.pcs = 2'd2;
    e.rw = 1'b1; e.wbs = 2'd2;
    tick(1'b1, 1'b0, 1'b0, e, "jalr_exec");

    // Ready arrives on the 16th fetch cycle: the handshake wins
    instr = 32'h00500093;
    do_fetch(15);
    do_decode(3'd0, "late_ready_decode");
    e = base(3'd3); e.aop = 2'd2; e.srcb = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "late_ready_exec");
    e = base(3'd5); e.rw = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "late_ready_wb");

    // No ready for 16 fetch cycles: trap, sticky even if ready shows up
    for (int i = 0; i < 16; i++) begin
      e = base(3'd1); e.mreq = 1'b1;
      tick(1'b1, 1'b0, 1'b0, e, "timeout_fetch");
    end
    e = base(3'd7); e.er = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "timeout_trap");
    tick(1'b1, 1'b1, 1'b0, e, "timeout_trap_sticky");
    do_reset(e, "timeout_trap_reset");

    // Branch with unsupported funct3 traps
    instr = 32'h00002463;
    do_fetch(0);
    do_decode(3'd2, "bad_branch_decode");
    e = base(3'd7); e.er = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "bad_branch_trap");
    do_reset(e, "bad_branch_reset");

    // Illegal opcode traps
    instr = 32'h0000007F;
    do_fetch(0);
    do_decode(3'd7, "illegal_decode");
    e = base(3'd7); e.er = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "illegal_trap");
    tick(1'b1, 1'b1, 1'b0, e, "illegal_trap_sticky");
    do_reset(e, "illegal_reset");

    // ebreak halts; no further memory requests
    instr = 32'h00100073;
    do_fetch(0);
    do_decode(3'd7, "ebreak_decode");
    e = base(3'd6); e.hlt = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, e, "halt_hold");
    do_reset(e, "halt_reset");

    // Reset asserted during MEM of a load
    instr = 32'h00012083;
    do_fetch(0);
    do_decode(3'd0, "lw2_decode");
    e = base(3'd3); e.srcb = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "lw2_exec");
    e = base(3'd4); e.mreq = 1'b1;
    do_reset(e, "lw2_mem_reset");
    e = base(3'd1); e.mreq = 1'b1;
    tick(1'b1, 1'b0, 1'b0, e, "post_reset_fetch");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected cycles left unchecked, expected 0",
               exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
